// File: rtl/rx_eb_rd_ctrl.sv
// Read-side controller for the RX elastic buffer: primes, drains and performs idle-based clock compensation.
// Optional statistics counters are enabled with `define RX_EB_STATS_EN.
module rx_eb_rd_ctrl #(
    parameter int               ADDRSIZE   = 5,
    parameter int               DSIZE      = 10,
    parameter logic [DSIZE-1:0] IDLE_CODE  = 10'h17C,
    parameter int               START_MARK = 16,
    parameter int               HI_MARK    = 20,
    parameter int               LO_MARK    = 12,
    parameter int               COMP_GAP   = 4
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                enable,
    input  logic                rempty,
    input  logic [ADDRSIZE:0]   rptr,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    input  logic [DSIZE-1:0]    rdata,
    output logic                rinc,
    output logic [DSIZE-1:0]    out_data,
    output logic                out_valid,
    output logic                out_fill,
    output logic [ADDRSIZE:0]   level,
    output logic                underflow,
    output logic                ovf_risk
`ifdef RX_EB_STATS_EN
    ,
    input  logic                stat_clr,
    output logic [15:0]         stat_ins,
    output logic [15:0]         stat_del,
    output logic [15:0]         stat_unf
`endif
);

    localparam int GW = (COMP_GAP < 2) ? 1 : $clog2(COMP_GAP + 1);
    localparam logic [ADDRSIZE:0] START_L = START_MARK[ADDRSIZE:0];
    localparam logic [ADDRSIZE:0] HI_L    = HI_MARK[ADDRSIZE:0];
    localparam logic [ADDRSIZE:0] LO_L    = LO_MARK[ADDRSIZE:0];
    localparam logic [ADDRSIZE:0] DEPTH_L = {1'b1, {ADDRSIZE{1'b0}}};
    localparam logic [GW-1:0]     GAP_L   = COMP_GAP[GW-1:0];

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
        logic [ADDRSIZE:0] b;
        b[ADDRSIZE] = g[ADDRSIZE];
        for (int i = ADDRSIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    state_t            state_r, state_next_s;
    logic [ADDRSIZE:0] level_r;
    logic              ovf_risk_r;
    logic [GW-1:0]     gap_r;
    logic [DSIZE-1:0]  out_data_r;
    logic              out_valid_r, out_fill_r, underflow_r;
    logic              rinc_s, del_s, ins_s, unf_s, vld_s, idle_head_s, gap_zero_s;
    logic [DSIZE-1:0]  data_s;

    assign idle_head_s = (rdata == IDLE_CODE);
    assign gap_zero_s  = (gap_r == {GW{1'b0}});

    // Fill level from the Gray pointers; modulo subtraction makes pointer wrap transparent
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            level_r    <= {(ADDRSIZE+1){1'b0}};
            ovf_risk_r <= 1'b0;
        end else begin
            level_r    <= gray2bin(rq2_wptr) - gray2bin(rptr);
            ovf_risk_r <= (level_r == DEPTH_L);
        end
    end

    // State register
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; dropping enable returns to IDLE from anywhere
    always_comb begin
        state_next_s = state_r;
        if (!enable) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:  state_next_s = ST_PRIME;
                ST_PRIME: begin
                    if ((level_r >= START_L) && !rempty) begin
                        state_next_s = ST_RUN;
                    end else begin
                        state_next_s = ST_PRIME;
                    end
                end
                ST_RUN: begin
                    if (rempty) begin
                        state_next_s = ST_PRIME;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end
                default:  state_next_s = ST_IDLE;
            endcase
        end
    end

    // Per-cycle RUN action: underflow, then delete, then insert, then normal pop
    always_comb begin
        rinc_s = 1'b0;
        del_s  = 1'b0;
        ins_s  = 1'b0;
        unf_s  = 1'b0;
        vld_s  = 1'b0;
        data_s = rdata;
        if ((state_r == ST_RUN) && enable) begin
            if (rempty) begin
                unf_s = 1'b1;
            end else if (idle_head_s && (level_r > HI_L) && gap_zero_s) begin
                del_s  = 1'b1;
                rinc_s = 1'b1;
            end else if (idle_head_s && (level_r < LO_L) && gap_zero_s) begin
                ins_s  = 1'b1;
                vld_s  = 1'b1;
                data_s = IDLE_CODE;
            end else begin
                rinc_s = 1'b1;
                vld_s  = 1'b1;
            end
        end else begin
            rinc_s = 1'b0;
        end
    end

    assign rinc = rinc_s;

    // Compensation spacing counter; cleared whenever PRIME is (re)entered
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            gap_r <= {GW{1'b0}};
        end else if ((state_next_s == ST_PRIME) && (state_r != ST_PRIME)) begin
            gap_r <= {GW{1'b0}};
        end else if (del_s || ins_s) begin
            gap_r <= GAP_L;
        end else if (!gap_zero_s) begin
            gap_r <= gap_r - GW'(1);
        end else begin
            gap_r <= gap_r;
        end
    end

    // Output register; out_data holds its last word while not valid
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            out_data_r  <= {DSIZE{1'b0}};
            out_valid_r <= 1'b0;
            out_fill_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (vld_s) begin
                out_data_r <= data_s;
            end else begin
                out_data_r <= out_data_r;
            end
            out_valid_r <= vld_s;
            out_fill_r  <= ins_s;
            underflow_r <= unf_s;
        end
    end

    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign out_fill  = out_fill_r;
    assign level     = level_r;
    assign underflow = underflow_r;
    assign ovf_risk  = ovf_risk_r;

`ifdef RX_EB_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic inc);
        return (inc && (c != 16'hFFFF)) ? (c + 16'd1) : c;
    endfunction

    logic [15:0] stat_ins_r, stat_del_r, stat_unf_r;

    // Saturating event counters; a clear beats a same-cycle increment
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            stat_ins_r <= 16'd0;
            stat_del_r <= 16'd0;
            stat_unf_r <= 16'd0;
        end else if (stat_clr) begin
            stat_ins_r <= 16'd0;
            stat_del_r <= 16'd0;
            stat_unf_r <= 16'd0;
        end else begin
            stat_ins_r <= sat_inc(stat_ins_r, ins_s);
            stat_del_r <= sat_inc(stat_del_r, del_s);
            stat_unf_r <= sat_inc(stat_unf_r, unf_s);
        end
    end

    assign stat_ins = stat_ins_r;
    assign stat_del = stat_del_r;
    assign stat_unf = stat_unf_r;
`endif

endmodule

// File: tb/tb_rx_eb_rd_ctrl.sv
// Bench for rx_eb_rd_ctrl: directed vector table plus a streaming run through a behavioural 32-deep FIFO.
module tb_rx_eb_rd_ctrl;

    logic       rclk = 1'b0;
    logic       rrst_n = 1'b0;
    logic       enable = 1'b0;
    logic       rempty, rinc, out_valid, out_fill, underflow, ovf_risk;
    logic [5:0] rptr, rq2_wptr, level;
    logic [9:0] rdata, out_data;

    int n_tests = 0;
    int n_fail  = 0;

    // direct-drive inputs used by the vector table
    logic       v_emp = 1'b0;
    logic [5:0] v_rb = 6'd0, v_wb = 6'd0;
    logic [9:0] v_rd = 10'd0;

    // behavioural FIFO used for streaming
    logic       use_model = 1'b0, wr_on = 1'b0, mon_on = 1'b0, primed = 1'b0;
    logic [9:0] mem [32];
    logic [5:0] m_rb, m_wb;
    logic [9:0] m_seq, exp_seq;
    logic       cyc_ph;
    int         rcvd = 0, unf_cnt = 0;

    always #5 rclk = ~rclk;

    function automatic logic [5:0] bin2gray(input logic [5:0] b);
        return b ^ (b >> 1);
    endfunction

    assign rempty   = use_model ? (m_rb == m_wb) : v_emp;
    assign rptr     = use_model ? bin2gray(m_rb) : bin2gray(v_rb);
    assign rq2_wptr = use_model ? bin2gray(m_wb) : bin2gray(v_wb);
    assign rdata    = use_model ? mem[m_rb[4:0]] : v_rd;

    rx_eb_rd_ctrl dut (
        .rclk(rclk), .rrst_n(rrst_n), .enable(enable), .rempty(rempty),
        .rptr(rptr), .rq2_wptr(rq2_wptr), .rdata(rdata), .rinc(rinc),
        .out_data(out_data), .out_valid(out_valid), .out_fill(out_fill),
        .level(level), .underflow(underflow), .ovf_risk(ovf_risk)
    );

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got 0x%0h, want 0x%0h", name, idx, act, exp);
        end
    endtask

    // FIFO model: one write every other cycle while wr_on, pop on rinc
    always @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            m_rb   <= 6'd0;
            m_wb   <= 6'd0;
            m_seq  <= 10'd1;
            cyc_ph <= 1'b0;
        end else begin
            cyc_ph <= ~cyc_ph;
            if (use_model && rinc && (m_rb != m_wb)) m_rb <= m_rb + 6'd1;
            if (use_model && wr_on && !cyc_ph && ((m_wb - m_rb) != 6'd32)) begin
                mem[m_wb[4:0]] <= m_seq;
                m_wb  <= m_wb + 6'd1;
                m_seq <= m_seq + 10'd1;
            end
        end
    end

    // Stream monitor: sequence order, priming level, underflow pulses
    always @(negedge rclk) begin
        if (mon_on && rrst_n) begin
            if (out_valid) begin
                chk("seq", rcvd, 32'(out_data), 32'(exp_seq));
                chk("seq_fill", rcvd, 32'(out_fill), 32'd0);
                exp_seq = exp_seq + 10'd1;
                rcvd++;
            end
            if (underflow) begin
                unf_cnt++;
                primed = 1'b0;
            end
            if (rinc && !primed) begin
                chk("prime_level_ge16", rcvd, 32'(level >= 6'd16), 32'd1);
                primed = 1'b1;
            end
        end
    end

    typedef struct {
        logic en; logic emp; logic [5:0] rb; logic [5:0] wb; logic [9:0] rd;
        logic x_rinc; logic x_vld; logic [9:0] x_data; logic x_fill; logic x_unf;
        logic [5:0] x_lvl; logic x_ovf;
    } vec_t;

    function automatic vec_t mk(input logic en, input logic emp, input int rb, input int wb, input int rd,
                                input logic xr, input logic xv, input int xd, input logic xf,
                                input logic xu, input int xl, input logic xo);
        vec_t v;
        v.en = en; v.emp = emp; v.rb = 6'(rb); v.wb = 6'(wb); v.rd = 10'(rd);
        v.x_rinc = xr; v.x_vld = xv; v.x_data = 10'(xd); v.x_fill = xf; v.x_unf = xu;
        v.x_lvl = 6'(xl); v.x_ovf = xo;
        return v;
    endfunction

    vec_t vt [37];

    initial begin
        // en emp rb wb rdata | rinc vld data fill unf level ovf
        vt[0]  = mk(1,0, 0,16,'h001, 0,0,'h000,0,0,16,0); // IDLE -> PRIME
        vt[1]  = mk(1,0, 0,16,'h001, 0,0,'h000,0,0,16,0); // PRIME -> RUN at 16
        vt[2]  = mk(1,0, 0,17,'h001, 1,1,'h001,0,0,17,0);
        vt[3]  = mk(1,0, 1,18,'h002, 1,1,'h002,0,0,17,0);
        vt[4]  = mk(1,0, 2,24,'h003, 1,1,'h003,0,0,22,0);
        vt[5]  = mk(1,0, 3,25,'h17C, 1,0,'h003,0,0,22,0); // delete
        vt[6]  = mk(1,0, 4,26,'h17C, 1,1,'h17C,0,0,22,0); // gap blocks
        vt[7]  = mk(1,0, 5,27,'h17C, 1,1,'h17C,0,0,22,0);
        vt[8]  = mk(1,0, 6,28,'h17C, 1,1,'h17C,0,0,22,0);
        vt[9]  = mk(1,0, 7,29,'h17C, 1,1,'h17C,0,0,22,0);
        vt[10] = mk(1,0, 8,30,'h17C, 1,0,'h17C,0,0,22,0); // second delete, 5 cycles later
        vt[11] = mk(1,0, 8,18,'h004, 1,1,'h004,0,0,10,0);
        vt[12] = mk(1,0, 9,19,'h17C, 1,1,'h17C,0,0,10,0); // low but gap blocks
        vt[13] = mk(1,0,10,20,'h005, 1,1,'h005,0,0,10,0); // non-idle passes
        vt[14] = mk(1,0,11,21,'h006, 1,1,'h006,0,0,10,0);
        vt[15] = mk(1,0,12,22,'h17C, 0,1,'h17C,1,0,10,0); // insert
        vt[16] = mk(1,0,12,22,'h17C, 1,1,'h17C,0,0,10,0);
        vt[17] = mk(1,0,13,22,'h007, 1,1,'h007,0,0, 9,0);
        vt[18] = mk(1,1,22,22,'h007, 0,0,'h007,0,1, 0,0); // underflow
        vt[19] = mk(1,1,22,22,'h007, 0,0,'h007,0,0, 0,0);
        vt[20] = mk(1,0,22,38,'h008, 0,0,'h007,0,0,16,0);
        vt[21] = mk(1,0,22,38,'h008, 0,0,'h007,0,0,16,0);
        vt[22] = mk(1,0,22,38,'h008, 1,1,'h008,0,0,16,0);
        vt[23] = mk(1,0,60,12,'h009, 1,1,'h009,0,0,16,0); // pointer wrap
        vt[24] = mk(1,0, 0,32,'h00A, 1,1,'h00A,0,0,32,0);
        vt[25] = mk(1,0, 0,32,'h00B, 1,1,'h00B,0,0,32,1); // ovf_risk
        vt[26] = mk(1,0, 1,20,'h00C, 1,1,'h00C,0,0,19,1);
        vt[27] = mk(1,0, 2,20,'h00D, 1,1,'h00D,0,0,18,0);
        vt[28] = mk(0,0, 2,20,'h00E, 0,0,'h00D,0,0,18,0); // disable: rinc drops now
        vt[29] = mk(0,0, 2,20,'h00E, 0,0,'h00D,0,0,18,0);
        vt[30] = mk(1,0, 2,20,'h00E, 0,0,'h00D,0,0,18,0);
        vt[31] = mk(1,0, 2,20,'h00E, 0,0,'h00D,0,0,18,0);
        vt[32] = mk(1,0, 2,20,'h00F, 1,1,'h00F,0,0,18,0); // 3-cycle entry latency
        vt[33] = mk(1,0, 0,20,'h17C, 1,1,'h17C,0,0,20,0);
        vt[34] = mk(1,0, 0,20,'h17C, 1,1,'h17C,0,0,20,0); // level 20: no delete
        vt[35] = mk(1,0, 0,12,'h17C, 1,1,'h17C,0,0,12,0);
        vt[36] = mk(1,0, 0,12,'h17C, 1,1,'h17C,0,0,12,0); // level 12: no insert

        // reset held with enable and a non-empty buffer
        enable = 1'b1; v_wb = 6'd20; v_rd = 10'h001;
        repeat (3) @(posedge rclk);
        @(negedge rclk);
        chk("rst_rinc", 0, 32'(rinc), 32'd0);
        chk("rst_valid", 0, 32'(out_valid), 32'd0);
        chk("rst_level", 0, 32'(level), 32'd0);
        chk("rst_data", 0, 32'(out_data), 32'd0);
        enable = 1'b0; v_wb = 6'd0;
        rrst_n = 1'b1;

        for (int i = 0; i < 37; i++) begin
            @(negedge rclk);
            enable = vt[i].en; v_emp = vt[i].emp; v_rb = vt[i].rb; v_wb = vt[i].wb; v_rd = vt[i].rd;
            #1;
            chk("rinc", i, 32'(rinc), 32'(vt[i].x_rinc));
            @(posedge rclk);
            #1;
            chk("valid", i, 32'(out_valid), 32'(vt[i].x_vld));
            chk("data", i, 32'(out_data), 32'(vt[i].x_data));
            chk("fill", i, 32'(out_fill), 32'(vt[i].x_fill));
            chk("underflow", i, 32'(underflow), 32'(vt[i].x_unf));
            chk("level", i, 32'(level), 32'(vt[i].x_lvl));
            chk("ovf_risk", i, 32'(ovf_risk), 32'(vt[i].x_ovf));
        end

        // asynchronous reset in the middle of a run
        @(negedge rclk);
        #2 rrst_n = 1'b0;
        #1;
        chk("arst_valid", 0, 32'(out_valid), 32'd0);
        chk("arst_data", 0, 32'(out_data), 32'd0);
        chk("arst_level", 0, 32'(level), 32'd0);
        chk("arst_rinc", 0, 32'(rinc), 32'd0);

        // stream through the FIFO model: slow writer, repeated prime/drain, pointer wrap
        use_model = 1'b1; wr_on = 1'b1; enable = 1'b1;
        exp_seq = 10'd1; primed = 1'b0; mon_on = 1'b1;
        @(negedge rclk);
        rrst_n = 1'b1;
        for (int c = 0; c < 3000 && rcvd < 200; c++) @(negedge rclk);
        chk("stream_200_words", 0, 32'(rcvd >= 200), 32'd1);

        // stop the writer while running: exactly one underflow, then idle in PRIME
        wr_on = 1'b0;
        unf_cnt = 0;
        repeat (100) @(negedge rclk);
        chk("stop_unf_once", 0, 32'(unf_cnt), 32'd1);
        chk("stop_all_delivered", 0, 32'(rcvd), 32'(m_seq - 10'd1));
        chk("stop_valid", 0, 32'(out_valid), 32'd0);
        chk("stop_rinc", 0, 32'(rinc), 32'd0);
        mon_on = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
